// File: rtl/word_tx_serializer_if.sv
// Word-in / byte-out handshake bundle between the debug unit, word_tx_serializer and uart_tx.
// master = word producer plus uart_tx side (testbench/system); slave = the serializer itself.
interface word_tx_serializer_if #(
    parameter int NB_WORD = 32,
    parameter int NB_BYTE = 8
);
    logic               i_wr;
    logic [NB_WORD-1:0] i_data;
    logic               o_full;
    logic               o_empty;
    logic               o_busy;
    logic               o_tx_start;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               i_tx_done_tick;

    modport master (
        output i_wr, i_data, i_tx_done_tick,
        input  o_full, o_empty, o_busy, o_tx_start, o_tx_data
    );

    modport slave (
        input  i_wr, i_data, i_tx_done_tick,
        output o_full, o_empty, o_busy, o_tx_start, o_tx_data
    );
endinterface

// File: rtl/word_tx_serializer.sv
// Word FIFO feeding uart_tx one byte at a time, least-significant byte first.
// Define WORD_TX_CHECKSUM_EN to append an XOR-of-bytes checksum byte to every word.
module word_tx_serializer #(
    parameter int NB_WORD = 32,
    parameter int NB_BYTE = 8,
    parameter int FIFO_W  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    word_tx_serializer_if.slave   bus
);
    localparam int NBYTES = NB_WORD / NB_BYTE;
    localparam int DEPTH  = 2 ** FIFO_W;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [FIFO_W-1:0] PTR_ONE  = FIFO_W'(1);

`ifdef WORD_TX_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, SEND, WAIT, CHK, CHK_WAIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, SEND, WAIT} state_t;
`endif

    state_t state_reg, state_next;

    logic [NB_WORD-1:0] mem [DEPTH];
    logic [FIFO_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_W-1:0]  wr_ptr_succ, rd_ptr_succ;
    logic               full_reg, empty_reg;
    logic               push, pop, advance;

    logic [NB_WORD-1:0] shift_reg;
    logic [CNT_W-1:0]   cnt_reg;
`ifdef WORD_TX_CHECKSUM_EN
    logic [NB_BYTE-1:0] csum_reg;
`endif

    // A push while full is dropped even if the FSM pops in the same cycle.
    assign push        = bus.i_wr && !full_reg;
    assign wr_ptr_succ = wr_ptr_reg + PTR_ONE;
    assign rd_ptr_succ = rd_ptr_reg + PTR_ONE;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= bus.i_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_succ;
            if (pop)
                rd_ptr_reg <= rd_ptr_succ;
            if (push && !pop) begin
                empty_reg <= 1'b0;
                full_reg  <= (wr_ptr_succ == rd_ptr_reg);
            end else if (pop && !push) begin
                full_reg  <= 1'b0;
                empty_reg <= (rd_ptr_succ == wr_ptr_reg);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        advance    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty_reg) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: state_next = WAIT;
            WAIT: begin
                if (bus.i_tx_done_tick) begin
                    if (cnt_reg == CNT_LAST) begin
`ifdef WORD_TX_CHECKSUM_EN
                        state_next = CHK;
`else
                        state_next = IDLE;
`endif
                    end else begin
                        advance    = 1'b1;
                        state_next = SEND;
                    end
                end
            end
`ifdef WORD_TX_CHECKSUM_EN
            CHK:      state_next = CHK_WAIT;
            CHK_WAIT: if (bus.i_tx_done_tick) state_next = IDLE;
`endif
            default:  state_next = IDLE;
        endcase
    end

    // Head word is read straight from the array into the shift register on pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (pop) begin
            shift_reg <= mem[rd_ptr_reg];
            cnt_reg   <= '0;
        end else if (advance) begin
            shift_reg <= shift_reg >> NB_BYTE;
            cnt_reg   <= cnt_reg + CNT_ONE;
        end
    end

`ifdef WORD_TX_CHECKSUM_EN
    // Fold each byte in during its SEND cycle so the checksum matches what went out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            csum_reg <= '0;
        else if (pop)
            csum_reg <= '0;
        else if (state_reg == SEND)
            csum_reg <= csum_reg ^ shift_reg[NB_BYTE-1:0];
    end
`endif

    always_comb begin
        bus.o_tx_start = (state_reg == SEND);
        bus.o_tx_data  = shift_reg[NB_BYTE-1:0];
`ifdef WORD_TX_CHECKSUM_EN
        if (state_reg == CHK)
            bus.o_tx_start = 1'b1;
        if (state_reg == CHK || state_reg == CHK_WAIT)
            bus.o_tx_data = csum_reg;
`endif
    end

    assign bus.o_busy  = (state_reg != IDLE);
    assign bus.o_full  = full_reg;
    assign bus.o_empty = empty_reg;

endmodule

// File: tb/tb_word_tx_serializer.sv
// Self-checking bench for word_tx_serializer: directed scenarios plus random traffic
// compared against a word-queue / byte-stream reference model.
module tb_word_tx_serializer;
    localparam int NB_WORD = 32;
    localparam int NB_BYTE = 8;
    localparam int FIFO_W  = 2;
    localparam int DEPTH   = 4;
    localparam int NBYTES  = 4;
`ifdef WORD_TX_CHECKSUM_EN
    localparam int FRAME = NBYTES + 1;
`else
    localparam int FRAME = NBYTES;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    word_tx_serializer_if #(.NB_WORD(NB_WORD), .NB_BYTE(NB_BYTE)) bus ();

    word_tx_serializer #(.NB_WORD(NB_WORD), .NB_BYTE(NB_BYTE), .FIFO_W(FIFO_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: accepted words awaiting transmission, and bytes expected on the line.
    logic [31:0] fifo_q [$];
    logic [7:0]  exp_q  [$];
    bit          m_busy, start_due;
    int          bytes_left;

    // Responder (acts as uart_tx) state.
    bit          waiting, fresh, hold_done, spur_en, force_done;
    int          timer, resp_delay, starts_seen;
    logic [7:0]  last_byte;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic observe();
        check_val("empty",    32'(bus.o_empty),    32'(fifo_q.size() == 0));
        check_val("full",     32'(bus.o_full),     32'(fifo_q.size() == DEPTH));
        check_val("busy",     32'(bus.o_busy),     32'(m_busy));
        check_val("tx_start", 32'(bus.o_tx_start), 32'(start_due));
        if (bus.o_tx_start) begin
            starts_seen++;
            if (exp_q.size() == 0) begin
                check_val("tx_unexpected", 32'(bus.o_tx_data), 32'hFFFF_FFFF);
            end else begin
                last_byte = exp_q.pop_front();
                check_val("tx_data", 32'(bus.o_tx_data), 32'(last_byte));
                $display("byte %02h sent at %0t", bus.o_tx_data, $time);
            end
            waiting = 1'b1;
            fresh   = 1'b1;
            timer   = (resp_delay < 0) ? int'($urandom_range(0, 5)) : resp_delay;
        end else if (waiting) begin
            check_val("tx_hold", 32'(bus.o_tx_data), 32'(last_byte));
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, then check outputs.
    task automatic tick(input bit wr, input logic [31:0] data);
        bit          done, genuine, acc;
        logic [31:0] w;
        logic [7:0]  b, x;
        done = 1'b0;
        genuine = 1'b0;
        if (fresh) begin
            done  = spur_en && ($urandom_range(0, 1) == 1);
            fresh = 1'b0;
        end else if (waiting) begin
            if (!hold_done) begin
                if (timer == 0) begin
                    done = 1'b1;
                    genuine = 1'b1;
                    waiting = 1'b0;
                end else begin
                    timer--;
                end
            end
        end else begin
            done = force_done || (spur_en && ($urandom_range(0, 3) == 0));
        end
        bus.i_wr = wr;
        bus.i_data = data;
        bus.i_tx_done_tick = done;
        @(posedge clk);
        acc = wr && (fifo_q.size() < DEPTH);
        start_due = 1'b0;
        if (!m_busy && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            x = 8'h00;
            for (int i = 0; i < NBYTES; i++) begin
                b = w[8*i +: 8];
                exp_q.push_back(b);
                x ^= b;
            end
`ifdef WORD_TX_CHECKSUM_EN
            exp_q.push_back(x);
`endif
            m_busy = 1'b1;
            bytes_left = FRAME;
            start_due = 1'b1;
        end else if (m_busy && genuine) begin
            bytes_left--;
            if (bytes_left == 0)
                m_busy = 1'b0;
            else
                start_due = 1'b1;
        end
        if (acc)
            fifo_q.push_back(data);
        @(negedge clk);
        observe();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 1000 && (m_busy || fifo_q.size() > 0 || waiting); i++)
            tick(1'b0, 32'h0);
        check_val(tag, 32'(m_busy || fifo_q.size() > 0 || waiting), 32'h0);
        tick(1'b0, 32'h0);
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_busy"},  32'(bus.o_busy),     32'h0);
        check_val({tag, "_start"}, 32'(bus.o_tx_start), 32'h0);
        check_val({tag, "_data"},  32'(bus.o_tx_data),  32'h0);
        check_val({tag, "_empty"}, 32'(bus.o_empty),    32'h1);
        check_val({tag, "_full"},  32'(bus.o_full),     32'h0);
    endtask

    initial begin
        int s0;
        reset = 1'b1;
        bus.i_wr = 1'b0;
        bus.i_data = '0;
        bus.i_tx_done_tick = 1'b0;
        hold_done = 1'b0; spur_en = 1'b0; force_done = 1'b0;
        waiting = 1'b0; fresh = 1'b0; m_busy = 1'b0; start_due = 1'b0;
        bytes_left = 0; timer = 0; starts_seen = 0; last_byte = 8'h00;
        resp_delay = 9;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;
        observe();

        // Single word, done tick 10 cycles after each start.
        s0 = starts_seen;
        tick(1'b1, 32'h1122_3344);
        drain("single_drain");
        check_val("single_bytes", 32'(starts_seen - s0), 32'(FRAME));

        // Back-to-back words.
        resp_delay = 2;
        tick(1'b1, 32'hDEAD_BEEF);
        tick(1'b1, 32'h0102_0304);
        drain("b2b_drain");

        // Fill the FIFO while the line is stalled; sixth push must be dropped.
        s0 = starts_seen;
        hold_done = 1'b1;
        for (int i = 1; i <= 6; i++)
            tick(1'b1, 32'hA000_0000 + 32'(i));
        repeat (3) tick(1'b0, 32'h0);
        hold_done = 1'b0;
        drain("full_drain");
        check_val("full_bytes", 32'(starts_seen - s0), 32'(5 * FRAME));

        // Random traffic with spurious done ticks in IDLE and SEND.
        spur_en = 1'b1;
        resp_delay = -1;
        for (int i = 0; i < 300; i++)
            tick($urandom_range(0, 2) == 0, $urandom());
        drain("rand1_drain");

        // Reset after the second byte of a word with two more queued.
        spur_en = 1'b0;
        resp_delay = 3;
        s0 = starts_seen;
        tick(1'b1, 32'hCAFE_F00D);
        tick(1'b1, $urandom());
        tick(1'b1, $urandom());
        for (int i = 0; i < 200 && (starts_seen - s0) < 2; i++)
            tick(1'b0, 32'h0);
        check_val("rst_reach", 32'((starts_seen - s0) >= 2), 32'h1);
        #2 reset = 1'b1;
        #1 check_reset_values("mid");
        fifo_q.delete();
        exp_q.delete();
        m_busy = 1'b0; start_due = 1'b0; waiting = 1'b0; fresh = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        observe();
        force_done = 1'b1;
        repeat (2) tick(1'b0, 32'h0);
        force_done = 1'b0;
        repeat (2) tick(1'b0, 32'h0);

        // More random traffic after the abort.
        spur_en = 1'b1;
        resp_delay = -1;
        for (int i = 0; i < 200; i++)
            tick($urandom_range(0, 1) == 0, $urandom());
        drain("rand2_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/word_tx_serializer.md
Name: word_tx_serializer

Overview:
- Buffers 32-bit words from the core (register/memory dump, debug results) in a small FIFO.
- Splits each word into bytes and drives uart_tx through its tx_start / tx_done_tick handshake.
- Host-bound counterpart of the byte-to-instruction assembler on the receive path.
- Sits between the datapath debug unit and uart_tx, sharing the baud tick domain.

Parameters:
- NB_WORD, 32, word width; must be a multiple of NB_BYTE.
- NB_BYTE, 8, UART data width (matches uart_tx DBIT).
- FIFO_W, 2, FIFO address bits; depth = 2**FIFO_W words (default 4).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- i_wr  in  1  push i_data into FIFO this cycle
- i_data  in  NB_WORD  word to send
- o_full  out  1  FIFO full; push ignored while high
- o_empty  out  1  FIFO empty
- o_busy  out  1  high whenever FSM not in IDLE
- o_tx_start  out  1  one-cycle start pulse to uart_tx
- o_tx_data  out  NB_BYTE  byte to uart_tx din
- i_tx_done_tick  in  1  uart_tx stop-bit-complete tick

Behaviour:
- Reset values:
  - FIFO pointers = 0; o_empty = 1; o_full = 0.
  - FSM = IDLE; o_busy = 0; o_tx_start = 0; o_tx_data = 0; byte counter = 0; shift register = 0.
- FIFO:
  - Push accepted iff i_wr && !o_full, evaluated in the same cycle. A push while full is dropped; no overwrite, no error flag.
  - Pop is internal, issued by the FSM in IDLE.
  - Simultaneous push and pop when full: pop occurs and the push is dropped.
  - Simultaneous push and pop when neither full nor empty: both occur; occupancy unchanged.
  - Pointers wrap modulo 2**FIFO_W.
  - o_full and o_empty are registered and reflect occupancy after the edge.
- FSM states:
  - IDLE: if !o_empty, pop the head word into the shift register, clear the byte counter, go to SEND. Otherwise stay in IDLE.
  - SEND: o_tx_start = 1 for exactly this one cycle. o_tx_data = shift[NB_BYTE-1:0]. Go to WAIT.
  - WAIT: hold o_tx_data stable. On i_tx_done_tick:
    - If counter == NB_WORD/NB_BYTE-1, go to IDLE (or CHK, see Optional Feature).
    - Otherwise shift right by NB_BYTE, increment the counter, go to SEND.
- Byte order: least-significant byte first. 0xAABBCCDD is sent as DD, CC, BB, AA.
- Latency:
  - Push into an empty FIFO with FSM in IDLE at edge t: pop at edge t+1; o_tx_start high during cycle t+1..t+2, i.e. first pulse 2 cycles after the i_wr cycle.
  - Subsequent bytes: o_tx_start is high the cycle after the edge that sampled i_tx_done_tick.
- Back-to-back words: IDLE takes one cycle between the last done tick of one word and the pop of the next. No gap bytes.
- i_tx_done_tick in IDLE or SEND is ignored.
- o_tx_start is never asserted outside SEND. o_tx_start is never asserted twice without an intervening i_tx_done_tick.
- Reset mid-frame: the frame is aborted, FIFO contents are discarded, and outputs return to reset values immediately. A byte already in uart_tx completes on the line; its done tick arrives in IDLE and is ignored.

Optional Feature:
- Macro: WORD_TX_CHECKSUM_EN.
- Defined:
  - After the last data byte's done tick, go to CHK.
  - CHK drives o_tx_start for one cycle with o_tx_data = XOR of all NB_WORD/NB_BYTE bytes of the word (accumulated as sent), then waits for i_tx_done_tick and goes to IDLE.
  - Frame = 5 bytes for default parameters.
  - Checksum accumulator resets to 0 on every pop.
- Undefined: CHK state and accumulator do not exist; frame = NB_WORD/NB_BYTE bytes.

Test Plan:
- Single word:
  - Stimulus: reset, then push 0x11223344; answer each o_tx_start with i_tx_done_tick 10 cycles later.
  - Required: o_tx_start first high 2 cycles after push; bytes 0x44, 0x33, 0x22, 0x11, each pulse exactly 1 cycle; o_busy falls one cycle after the 4th done tick; o_empty = 1.
- FIFO full:
  - Stimulus: hold i_tx_done_tick low; push 0xA0000001, 0xA0000002, 0xA0000003, 0xA0000004, 0xA0000005, 0xA0000006 on consecutive cycles.
  - Required: first word popped; o_full asserts after the 5th push; 6th dropped. Bytes sent total 20, ending with word 0xA0000005.
- Back-to-back:
  - Stimulus: push 0xDEADBEEF and 0x01020304 together.
  - Required: byte stream EF BE AD DE 04 03 02 01; 2 cycles between the 4th done tick and the next o_tx_start.
- Spurious ticks:
  - Stimulus: i_tx_done_tick pulses while idle and in the SEND cycle.
  - Required: no o_tx_start, no counter advance, no byte skipped.
- Reset mid-frame:
  - Stimulus: assert reset after the 2nd byte of 0xCAFEF00D, with 2 more words queued.
  - Required: all outputs at reset values immediately; o_empty = 1; a later done tick produces no o_tx_start.
- Checksum (WORD_TX_CHECKSUM_EN defined):
  - Stimulus: push 0x11223344.
  - Required: bytes 44 33 22 11 then 0x44; five o_tx_start pulses total.
